// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arbiter_pkg;

    localparam int DMEM_ARB_ADDR_W   = 12;
    localparam int DMEM_ARB_DATA_W   = 32;
    localparam int DMEM_ARB_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_DBG  = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Bounded-wait counter for the debug requester; force_dbg is raised once
// debug has been denied MAX_WAIT consecutive cycles.
module dmem_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam int               CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_dbg = (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between CPU (priority) and debug reads.
// Optional grant statistics counters are enabled with DMEM_ARB_STATS_EN.
//
// rd_owner state | meaning
// RD_NONE        | no read returning this cycle
// RD_CPU         | mem_rdata belongs to the CPU read granted last cycle
// RD_DBG         | mem_rdata belongs to the debug read granted last cycle
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ARB_ADDR_W,
    parameter int DATA_W   = DMEM_ARB_DATA_W,
    parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       cpu_acc_cnt,
    output logic [31:0]       dbg_acc_cnt,
    output logic [31:0]       forced_cnt
`endif
);

    logic      force_dbg;
    rd_owner_e rd_owner_q;
    rd_owner_e rd_owner_d;

    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .dbg_req   (dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );

    // Grants are gated by rst so nothing reaches memory while reset is held.
    always_comb begin
        cpu_gnt   = rst & cpu_req & ~(dbg_req & force_dbg);
        dbg_gnt   = rst & dbg_req & (~cpu_req | force_dbg);
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_we ? cpu_wdata : '0;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = dbg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner_q <= RD_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        rd_owner_d = RD_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = RD_CPU;
        end else if (dbg_gnt) begin
            rd_owner_d = RD_DBG;
        end
    end

    always_comb begin
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        case (rd_owner_q)
            RD_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
            end
            RD_DBG: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] cpu_acc_cnt_q, cpu_acc_cnt_d;
    logic [31:0] dbg_acc_cnt_q, dbg_acc_cnt_d;
    logic [31:0] forced_cnt_q,  forced_cnt_d;

    always_comb begin
        cpu_acc_cnt_d = cpu_acc_cnt_q + {31'd0, cpu_gnt};
        dbg_acc_cnt_d = dbg_acc_cnt_q + {31'd0, dbg_gnt};
        forced_cnt_d  = forced_cnt_q  + {31'd0, dbg_gnt & force_dbg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_acc_cnt_q <= '0;
            dbg_acc_cnt_q <= '0;
            forced_cnt_q  <= '0;
        end else begin
            cpu_acc_cnt_q <= cpu_acc_cnt_d;
            dbg_acc_cnt_q <= dbg_acc_cnt_d;
            forced_cnt_q  <= forced_cnt_d;
        end
    end

    assign cpu_acc_cnt = cpu_acc_cnt_q;
    assign dbg_acc_cnt = dbg_acc_cnt_q;
    assign forced_cnt  = forced_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: grant checks inline per scenario,
// read returns checked against a queue of expected data/cycle pairs.
module tb_dmem_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_gnt, dbg_rvalid;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] cpu_acc_cnt, dbg_acc_cnt, forced_cnt;
`endif

    logic [31:0] mem     [0:4095];
    logic [31:0] exp_mem [0:4095];
    exp_t        cpu_q[$];
    exp_t        dbg_q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    dmem_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .cpu_acc_cnt (cpu_acc_cnt),
        .dbg_acc_cnt (dbg_acc_cnt),
        .forced_cnt  (forced_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous-read memory model, one cycle read latency.
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0100_0000 + i;
        mem[12'h010] = 32'h1234_5678;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
                else mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic mon_rvalid();
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_q.size() != 0 && cpu_q[0].cyc <= cyc) begin
                e = cpu_q.pop_front();
                checks++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL cpu_read_return: cyc=%0d rvalid=%b rdata=%h required rvalid=1 rdata=%h at cyc=%0d",
                             cyc, cpu_rvalid, cpu_rdata, e.data, e.cyc);
                end
            end else if (cpu_rvalid !== 1'b0) begin
                checks++; errors++;
                $display("FAIL cpu_rvalid_spurious: cyc=%0d rvalid=%b required 0", cyc, cpu_rvalid);
            end
            if (dbg_q.size() != 0 && dbg_q[0].cyc <= cyc) begin
                e = dbg_q.pop_front();
                checks++;
                if (dbg_rvalid !== 1'b1 || dbg_rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dbg_read_return: cyc=%0d rvalid=%b rdata=%h required rvalid=1 rdata=%h at cyc=%0d",
                             cyc, dbg_rvalid, dbg_rdata, e.data, e.cyc);
                end
            end else if (dbg_rvalid !== 1'b0) begin
                checks++; errors++;
                $display("FAIL dbg_rvalid_spurious: cyc=%0d rvalid=%b required 0", cyc, dbg_rvalid);
            end
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        cpu_req = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, mem_en, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grants: gnt/en/we=%b required 0000", {cpu_gnt, dbg_gnt, mem_en, mem_we});
        end
        checks++;
        if ({cpu_rvalid, dbg_rvalid} !== 2'b00 || cpu_rdata !== '0 || dbg_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: rvalid=%b cpu_rdata=%h dbg_rdata=%h required all 0",
                     {cpu_rvalid, dbg_rvalid}, cpu_rdata, dbg_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_en !== 1'b1 ||
            mem_we !== 1'b0 || mem_addr !== 12'h010 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL cpu_read_grant: gnt=%b dgnt=%b stall=%b en=%b we=%b addr=%h wdata=%h required 1 0 0 1 0 010 0",
                     cpu_gnt, dbg_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata);
        end
        cpu_q.push_back('{exp_mem[12'h010], cyc + 1});
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== '0 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_dbg_quiet: dbg_rvalid=%b dbg_rdata=%h dbg_gnt=%b required 0", dbg_rvalid, dbg_rdata, dbg_gnt);
        end
        @(negedge clk);
    endtask

    task automatic test_dbg_write_read();
        int we_pulses = 0;
        dbg_req = 1; dbg_addr = 12'h004;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 12'h004 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL dbg_read_grant: dgnt=%b cgnt=%b addr=%h en=%b required 1 0 004 1", dbg_gnt, cpu_gnt, mem_addr, mem_en);
        end
        if (mem_we === 1'b1) we_pulses++;
        dbg_q.push_back('{exp_mem[12'h004], cyc + 1});
        @(negedge clk);
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h004; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h004 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cpu_write_grant: gnt=%b we=%b addr=%h wdata=%h required 1 1 004 deadbeef", cpu_gnt, mem_we, mem_addr, mem_wdata);
        end
        if (mem_we === 1'b1) we_pulses++;
        exp_mem[12'h004] = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        dbg_req = 1; dbg_addr = 12'h004;
        #1;
        if (mem_we === 1'b1) we_pulses++;
        dbg_q.push_back('{exp_mem[12'h004], cyc + 1});
        @(negedge clk);
        idle_inputs();
        #1;
        if (mem_we === 1'b1) we_pulses++;
        checks++;
        if (we_pulses != 1) begin
            errors++;
            $display("FAIL write_pulse_count: got %0d required 1", we_pulses);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic exp_dbg;
`ifdef DMEM_ARB_STATS_EN
        logic [31:0] c0, d0, f0;
`endif
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
        dbg_req = 1; dbg_addr = 12'h030;
`ifdef DMEM_ARB_STATS_EN
        c0 = cpu_acc_cnt; d0 = dbg_acc_cnt; f0 = forced_cnt;
`endif
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_dbg = ((i % 5) == 4);
            checks++;
            if (dbg_gnt !== exp_dbg || cpu_gnt !== !exp_dbg || cpu_stall !== exp_dbg ||
                mem_addr !== (exp_dbg ? 12'h030 : 12'h020)) begin
                errors++;
                $display("FAIL starve_cycle%0d: cgnt=%b dgnt=%b stall=%b addr=%h required cgnt=%b dgnt=%b stall=%b",
                         i, cpu_gnt, dbg_gnt, cpu_stall, mem_addr, !exp_dbg, exp_dbg, exp_dbg);
            end
            if (exp_dbg) dbg_q.push_back('{exp_mem[12'h030], cyc + 1});
            else cpu_q.push_back('{exp_mem[12'h020], cyc + 1});
            @(negedge clk);
        end
        idle_inputs();
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if (cpu_acc_cnt - c0 !== 32'd8 || dbg_acc_cnt - d0 !== 32'd2 || forced_cnt - f0 !== 32'd2) begin
            errors++;
            $display("FAIL stats_counts: cpu=%0d dbg=%0d forced=%0d required 8 2 2",
                     cpu_acc_cnt - c0, dbg_acc_cnt - d0, forced_cnt - f0);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 3; a++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 12'(a);
            #1;
            checks++;
            if (cpu_gnt !== 1'b1 || mem_addr !== 12'(a)) begin
                errors++;
                $display("FAIL b2b_grant%0d: gnt=%b addr=%h required 1 %h", a, cpu_gnt, mem_addr, 12'(a));
            end
            cpu_q.push_back('{exp_mem[a], cyc + 1});
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        dbg_req = 1; dbg_addr = 12'h004;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1) begin
            errors++;
            $display("FAIL inflight_grant: dgnt=%b required 1", dbg_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({dbg_rvalid, cpu_rvalid, dbg_gnt, cpu_gnt, mem_en, mem_we} !== 6'b0 ||
                dbg_rdata !== '0 || cpu_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL inflight_dropped%0d: rv=%b%b gnt=%b%b en=%b drdata=%h required all 0",
                         i, dbg_rvalid, cpu_rvalid, dbg_gnt, cpu_gnt, mem_en, dbg_rdata);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 12'h010) begin
            errors++;
            $display("FAIL post_reset_grant: gnt=%b en=%b addr=%h required 1 1 010", cpu_gnt, mem_en, mem_addr);
        end
        cpu_q.push_back('{exp_mem[12'h010], cyc + 1});
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) exp_mem[i] = 32'h0100_0000 + i;
        exp_mem[12'h010] = 32'h1234_5678;
        test_reset();
        fork
            mon_rvalid();
        join_none
        test_cpu_read();
        test_dbg_write_read();
        test_starvation();
        test_back_to_back();
        test_reset_inflight();
        @(negedge clk); #2;
        checks++;
        if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
            errors++;
            $display("FAIL pending_returns: cpu=%0d dbg=%0d required 0 0", cpu_q.size(), dbg_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
